// File: rtl/rcpu_io_pkg.sv
// Shared constants for the RCPU I/O bus peripherals: register addresses,
// UART STATUS bit positions, serial FSM states and divisor floor.
package rcpu_io_pkg;

    localparam logic [15:0] ADDR_UART_DATA   = 16'h0000;
    localparam logic [15:0] ADDR_UART_STATUS = 16'h0004;
    localparam logic [15:0] ADDR_UART_DIV    = 16'h0008;
    localparam logic [15:0] ADDR_UART_CTRL   = 16'h000C;

    localparam int ST_RX_AVAIL     = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_TX_IDLE      = 2;
    localparam int ST_RX_OVERRUN   = 3;
    localparam int ST_RX_FRAME_ERR = 4;
    localparam int ST_TX_OVERFLOW  = 5;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/rcpu_io_fifo.sv
// Synchronous FIFO with fall-through read data; a pop frees room for a
// push in the same cycle, so a full FIFO accepts push+pop together.
module rcpu_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rcpu_uart_io.sv
// Memory-mapped UART on the RCPU SYS I/O bus (DATA/STATUS/DIVISOR/CTRL).
// Build option RCPU_UART_LOOPBACK_EN adds the CTRL loopback bit.
module rcpu_uart_io
    import rcpu_io_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] CLK_DIV_DEFAULT = 16'd104
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_read_enable,
    input  logic        io_write_enable,
    input  logic [0:15] io_address,
    input  logic [0:15] io_write_data,
    output logic [0:15] io_read_data,
    output logic        uart_txd,
    input  logic        uart_rxd
);
    // Bus vectors are MSB-first; internal copies use conventional numbering.
    logic [15:0] addr, wdata, rd_val, divisor;
    assign addr  = io_address;
    assign wdata = io_write_data;

    logic wr_data, wr_div, rd_data, rd_status;
    assign wr_data   = io_write_enable && (addr == ADDR_UART_DATA);
    assign wr_div    = io_write_enable && (addr == ADDR_UART_DIV);
    assign rd_data   = io_read_enable  && (addr == ADDR_UART_DATA);
    assign rd_status = io_read_enable  && (addr == ADDR_UART_STATUS);

    logic loop_en;
`ifdef RCPU_UART_LOOPBACK_EN
    logic wr_ctrl;
    assign wr_ctrl = io_write_enable && (addr == ADDR_UART_CTRL);
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)      loop_en <= 1'b0;
        else if (wr_ctrl) loop_en <= wdata[0];
    end
`else
    assign loop_en = 1'b0;
`endif

    logic [7:0] tx_rdata, rx_rdata, tx_shift, rx_shift;
    logic       tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
    logic       tx_line, rx_s1, rx_s2, rx_s3;
    logic       rx_overrun, rx_frame_err, tx_overflow;

    rcpu_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .resetq(resetq), .push(wr_data), .wdata(wdata[7:0]),
        .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );

    rcpu_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .resetq(resetq), .push(rx_push), .wdata(rx_shift),
        .pop(rd_data), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    uart_state_t tx_state, rx_state;
    logic [15:0] tx_cnt, tx_div, rx_cnt, rx_div;
    logic [2:0]  tx_bit, rx_bit;

    // STOP can hand straight over to the next START, so frames run back to back.
    assign tx_pop = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == 16'd0));

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= CLK_DIV_DEFAULT;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= S_START;
            tx_shift <= tx_rdata;
            tx_div   <= divisor;
            tx_cnt   <= divisor - 16'd1;
            tx_line  <= 1'b0;
        end else if (tx_state != S_IDLE) begin
            if (tx_cnt != 16'd0) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else begin
                tx_cnt <= tx_div - 16'd1;
                unique case (tx_state)
                    S_START: begin
                        tx_line  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= 3'd0;
                        tx_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_line  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= loop_en ? tx_line : uart_rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    logic rx_sample;
    assign rx_sample = (rx_state != S_IDLE) && (rx_cnt == 16'd0);
    assign rx_push   = rx_sample && (rx_state == S_STOP) && rx_s2;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= CLK_DIV_DEFAULT;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else if (rx_state == S_IDLE) begin
            if (rx_s3 && !rx_s2) begin
                rx_div   <= divisor;
                rx_cnt   <= (divisor >> 1) - 16'd1;
                rx_state <= S_START;
            end
        end else if (!rx_sample) begin
            rx_cnt <= rx_cnt - 16'd1;
        end else begin
            rx_cnt <= rx_div - 16'd1;
            unique case (rx_state)
                S_START: begin
                    rx_bit   <= 3'd0;
                    rx_state <= rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= S_STOP;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a STATUS read survives the clear.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_overflow  <= 1'b0;
            divisor      <= CLK_DIV_DEFAULT;
            io_read_data <= '0;
        end else begin
            rx_overrun   <= (rx_push && rx_full && !rd_data) || (rx_overrun && !rd_status);
            rx_frame_err <= (rx_sample && rx_state == S_STOP && !rx_s2) || (rx_frame_err && !rd_status);
            tx_overflow  <= (wr_data && tx_full && !tx_pop) || (tx_overflow && !rd_status);
            if (wr_div)         divisor      <= clamp_div(wdata);
            if (io_read_enable) io_read_data <= rd_val;
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (addr)
            ADDR_UART_DATA:   rd_val = rx_empty ? 16'h0000 : {8'h00, rx_rdata};
            ADDR_UART_STATUS: begin
                rd_val[ST_RX_AVAIL]     = !rx_empty;
                rd_val[ST_TX_FULL]      = tx_full;
                rd_val[ST_TX_IDLE]      = tx_empty && (tx_state == S_IDLE);
                rd_val[ST_RX_OVERRUN]   = rx_overrun;
                rd_val[ST_RX_FRAME_ERR] = rx_frame_err;
                rd_val[ST_TX_OVERFLOW]  = tx_overflow;
            end
            ADDR_UART_DIV:    rd_val = divisor;
            ADDR_UART_CTRL:   rd_val = {15'h0000, loop_en};
            default:          rd_val = '0;
        endcase
    end

    assign uart_txd = tx_line || loop_en;

endmodule

// File: tb/tb_rcpu_uart_io.sv
// Directed bench for rcpu_uart_io: register access, TX bit timing, RX framing,
// FIFO overflow/overrun, reset mid-frame and (when built in) loopback.
module tb_rcpu_uart_io;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_read_enable = 1'b0;
    logic        io_write_enable = 1'b0;
    logic [0:15] io_address = '0;
    logic [0:15] io_write_data = '0;
    logic [0:15] io_read_data;
    logic        uart_txd;
    logic        uart_rxd = 1'b1;

    int total = 0;
    int bad   = 0;

    rcpu_uart_io #(.FIFO_DEPTH(8), .CLK_DIV_DEFAULT(16'd104)) dut (
        .clk(clk), .resetq(resetq),
        .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        io_address = a; io_write_data = d; io_write_enable = 1'b1;
        @(negedge clk);
        io_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        io_address = a; io_read_enable = 1'b1;
        @(negedge clk);
        io_read_enable = 1'b0;
        d = io_read_data;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int div);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (div) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rd;
        logic [9:0]  frame;
        logic [7:0]  exp_b;
        int          zeros;
        bit          idle_seen;

        repeat (3) @(negedge clk);
        check("reset_txd", {15'h0, uart_txd}, 16'h0001);
        resetq = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(16'h0004, rd); check("reset_status", rd, 16'h0004);
        bus_read(16'h0008, rd); check("reset_div", rd, 16'h0068);
        bus_read(16'h0000, rd); check("reset_data_empty", rd, 16'h0000);

        bus_write(16'h0008, 16'h0002);
        bus_read(16'h0008, rd); check("div_clamp", rd, 16'h0004);
        bus_write(16'h0008, 16'h0004);
        bus_read(16'h0008, rd); check("div_write4", rd, 16'h0004);

        // TX 0x55 at divisor 4: start, LSB-first data, stop, 4 cycles each
        bus_write(16'h0000, 16'h0055);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("tx55_bit", {15'h0, uart_txd}, {15'h0, frame[k]});
            end
        end
        repeat (3) @(negedge clk);
        bus_read(16'h0004, rd); check("tx55_idle", rd, 16'h0004);

        // RX 0xA3 at divisor 8, with read-data hold
        bus_write(16'h0008, 16'h0008);
        send_rx(8'hA3, 1'b1, 8);
        bus_read(16'h0004, rd); check("rx_a3_status", rd, 16'h0005);
        bus_read(16'h0000, rd); check("rx_a3_data", rd, 16'h00A3);
        repeat (2) @(negedge clk);
        check("rx_a3_hold", io_read_data, 16'h00A3);
        bus_read(16'h0004, rd); check("rx_a3_status_after", rd, 16'h0004);

        // Short low pulse is rejected at the START sample
        @(negedge clk); uart_rxd = 1'b0;
        repeat (2) @(negedge clk); uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(16'h0004, rd); check("glitch_status", rd, 16'h0004);

        // Stop bit 0: no push, frame error sticky until STATUS read
        send_rx(8'h5A, 1'b0, 8);
        bus_read(16'h0004, rd); check("frame_err_status", rd, 16'h0014);
        bus_read(16'h0004, rd); check("frame_err_cleared", rd, 16'h0004);
        bus_read(16'h0000, rd); check("frame_err_nopush", rd, 16'h0000);

        // Nine bytes into an 8-deep RX FIFO
        for (int i = 0; i < 9; i++) send_rx(8'(i * 31 + 5), 1'b1, 8);
        bus_read(16'h0004, rd); check("overrun_status", rd, 16'h000D);
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'(i * 31 + 5);
            bus_read(16'h0000, rd); check("overrun_order", rd, {8'h00, exp_b});
        end
        bus_read(16'h0004, rd); check("overrun_drained", rd, 16'h0004);

        // TX overflow: one byte in flight, then nine more into 8 slots
        bus_write(16'h0008, 16'h0004);
        bus_write(16'h0000, 16'h0011);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) bus_write(16'h0000, 16'(8'h20 + i));
        bus_read(16'h0004, rd); check("tx_overflow_status", rd, 16'h0022);
        bus_read(16'h0004, rd); check("tx_overflow_cleared", rd, 16'h0002);
        idle_seen = 1'b0;
        for (int p = 0; p < 80 && !idle_seen; p++) begin
            repeat (10) @(negedge clk);
            bus_read(16'h0004, rd);
            if (rd[2]) idle_seen = 1'b1;
        end
        check("tx_drain_idle", rd, 16'h0004);

        bus_read(16'h0010, rd); check("unmapped_read", rd, 16'h0000);
        bus_write(16'h0010, 16'hFFFF);
        bus_read(16'h0008, rd); check("unmapped_write_div", rd, 16'h0004);

`ifdef RCPU_UART_LOOPBACK_EN
        bus_write(16'h000C, 16'h0001);
        bus_read(16'h000C, rd); check("ctrl_loop_set", rd, 16'h0001);
        bus_write(16'h0000, 16'h003C);
        zeros = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) zeros++;
        end
        check("loop_txd_high", 16'(zeros), 16'h0000);
        bus_read(16'h0000, rd); check("loop_data", rd, 16'h003C);
        bus_write(16'h000C, 16'h0000);
`else
        bus_write(16'h000C, 16'h0001);
        bus_read(16'h000C, rd); check("ctrl_absent", rd, 16'h0000);
        zeros = 0;
`endif

        // Reset during a TX data bit of 0x00
        bus_write(16'h0000, 16'h0000);
        repeat (10) @(negedge clk);
        check("midframe_txd_low", {15'h0, uart_txd}, 16'h0000);
        resetq = 1'b0;
        #1;
        check("midframe_reset_txd", {15'h0, uart_txd}, 16'h0001);
        repeat (2) @(negedge clk);
        resetq = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(16'h0004, rd); check("midframe_status", rd, 16'h0004);
        bus_read(16'h0008, rd); check("midframe_div", rd, 16'h0068);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rcpu_uart_io.md
Name: rcpu_uart_io

Overview:
Memory-mapped UART peripheral that sits directly downstream of the RCPU core's SYS I/O port. It consumes io_read_enable, io_write_enable, io_address and io_write_data, and returns io_read_data. TX and RX paths each have a FIFO and a bit-serial shifter with a programmable baud divisor. It is the first real peripheral on the I/O bus and gives the core console I/O.

Parameters:
FIFO_DEPTH, 8, entries per TX and RX FIFO; must be a power of two, minimum 2.
CLK_DIV_DEFAULT, 104, reset value of the baud divisor in clk cycles per bit (12 MHz / 115200).

Ports:
clk  input  1  system clock
resetq  input  1  asynchronous active-low reset
io_read_enable  input  1  one-cycle read strobe from core
io_write_enable  input  1  one-cycle write strobe from core
io_address  input  16  word address, [0:15], index 15 = LSB, low two bits always 0
io_write_data  input  16  write data, [0:15]
io_read_data  output  16  registered read data, [0:15]
uart_txd  output  1  serial out, idle high
uart_rxd  input  1  serial in, asynchronous to clk

Behaviour:
- Reset (async, resetq=0): uart_txd=1, io_read_data=0, FIFOs empty, sticky flags 0, divisor=CLK_DIV_DEFAULT, TX/RX FSMs IDLE.
- Register map (io_address):
  - 0x0000 DATA: write pushes io_write_data[8:15] into TX FIFO; read pops RX FIFO and returns {8'b0, byte}.
  - 0x0004 STATUS (read-only; bits by LSB weight): 0 rx_avail, 1 tx_full, 2 tx_idle (FIFO empty and shifter IDLE), 3 rx_overrun, 4 rx_frame_err, 5 tx_overflow; other bits 0. A read clears bits 3..5 after capturing them.
  - 0x0008 DIVISOR (R/W): 16-bit. A written value below 4 is stored as 4.
  - 0x000C CTRL: see Optional Feature. Reads 0 and ignores writes when the feature is compiled out.
  - Any other address: reads return 0; writes are ignored.
- Read timing: io_read_data is loaded on the clk edge where io_read_enable=1 and then held until the next read. The core samples it two cycles later, so the hold is mandatory.
- Read and write asserted in the same cycle: both take effect. The read returns the pre-write state. On DATA, the TX push and RX pop are independent.
- TX FIFO full on write: byte dropped, tx_overflow set.
- RX FIFO empty on read: return 0x0000, FIFO pointers unchanged.
- Flag set and STATUS read in the same cycle: the set wins; the flag stays 1 after the read.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with FIFO non-empty: pop a byte, latch the current divisor, enter START.
  - Each bit is held for exactly divisor cycles. Bit order is start(0), 8 data bits LSB first, stop(1).
  - After STOP, return to IDLE. Back-to-back bytes have no extra idle cycle.
- RX path: 2-flop synchronizer on uart_rxd. RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a 1-to-0 transition on the synced line latches the divisor and enters START.
  - START: sample at divisor/2 (floor). If the line is high, treat it as a glitch and return to IDLE.
  - DATA: sample each bit every divisor cycles after the START sample.
  - STOP: if the sample is 0, set rx_frame_err and drop the byte. Otherwise push the byte; if the FIFO is full, drop it and set rx_overrun.
  - Return to IDLE on the same sample cycle.
- A DIVISOR write mid-frame does not affect the frame in progress; it applies from the next frame.
- A FIFO push and pop in the same cycle on a full or empty FIFO behaves as pop-then-push, with count unchanged when both are legal.

Optional Feature:
- Macro: RCPU_UART_LOOPBACK_EN.
- Defined: CTRL bit 0 (LSB) is R/W loopback, reset 0.
  - When 1: the RX synchronizer input is taken from the internal TX serial output instead of uart_rxd, and uart_txd is forced to 1.
  - Switching the bit mid-frame may corrupt that frame; no other guarantee is made.
- Undefined: CTRL reads 0 and writes are ignored. uart_rxd always feeds RX.

Decomposition:
- Package rcpu_io_pkg holds:
  - address constants (ADDR_UART_DATA=0x0000, ADDR_UART_STATUS=0x0004, ADDR_UART_DIV=0x0008, ADDR_UART_CTRL=0x000C);
  - STATUS bit indices;
  - TX/RX state encodings;
  - minimum divisor constant 4.
- One sub-module, rcpu_io_fifo: synchronous FIFO parameterised on width and depth, with full, empty, push and pop. It is instantiated once for TX and once for RX.

Test Plan:
- Reset mid-frame: resetq=0 during a TX data bit -> uart_txd=1 immediately; STATUS read after release returns 0x0004.
- DIVISOR=4, write DATA 0x0055 -> uart_txd low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high; STATUS bit 2 returns to 1.
- Drive uart_rxd with byte 0xA3 at divisor 8 -> STATUS bit 0=1; DATA read returns 0x00A3 and holds for at least 2 cycles; the next STATUS read shows bit 0=0.
- Write 9 bytes with FIFO_DEPTH=8 while TX is busy -> STATUS=0x0022 (tx_full + tx_overflow); a second STATUS read clears bit 5.
- Receive a frame with stop bit 0 -> no push, rx_frame_err=1. Receive 9 bytes without reading -> rx_overrun=1 and the first 8 bytes are returned in order.
- With RCPU_UART_LOOPBACK_EN defined, CTRL=1, write 0x003C -> uart_txd stays 1; DATA read returns 0x003C.
